// File: rtl/fpro_arb_pkg.sv
// ---------------------------------------------------------------------------
// fpro_arb_pkg
// Shared definitions for the FPro MMIO two-master arbiter:
//   - arb_state_t : arbiter FSM states (IDLE, ISSUE, ACK)
//   - NUM_REQ     : number of bus masters sharing the MMIO bus
//   - ADDR_W      : default MMIO word-address width
//   - DATA_W      : default MMIO data width
// ---------------------------------------------------------------------------
package fpro_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 21;
  localparam int DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fpro_rr_pick.sv
// ---------------------------------------------------------------------------
// fpro_rr_pick
// Combinational two-way round-robin selector.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  1        index of the requester granted most recently
//   grant_idx  out 1        index of the winning requester (valid with any_req)
//   any_req    out 1        at least one request is pending
// ---------------------------------------------------------------------------
module fpro_rr_pick
  import fpro_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_grant,
  output logic               grant_idx,
  output logic               any_req
);

  // A lone request wins outright; under contention the requester that was
  // not served last gets the bus, which gives strict alternation.
  always_comb begin
    any_req   = |req;
    grant_idx = 1'b0;
    case (req)
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpro_mmio_arbiter.sv
// ---------------------------------------------------------------------------
// fpro_mmio_arbiter
// Shares the FPro MMIO bus between the CPU bridge (requester 0) and a
// secondary master (requester 1). One requester is granted at a time with
// round-robin fairness; each transaction produces exactly one registered
// single-cycle MMIO strobe followed by a one-cycle acknowledge.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   req_i, rd_i, wr_i          per-requester request / read / write
//   addr0_i, addr1_i           requester addresses
//   wr_data0_i, wr_data1_i     requester write data
//   ack_o, err_o, rd_data_o    completion pulse, illegal-command flag, read data
//   mmio_cs, mmio_read,
//   mmio_write, mmio_addr,
//   mmio_wr_data               MMIO bus master outputs
//   mmio_rd_data               MMIO read data, valid during the read strobe
// ---------------------------------------------------------------------------
module fpro_mmio_arbiter
  import fpro_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ-1:0]    rd_i,
  input  logic [NUM_REQ-1:0]    wr_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wr_data0_i,
  input  logic [DATA_WIDTH-1:0] wr_data1_i,
  output logic [NUM_REQ-1:0]    ack_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  mmio_cs,
  output logic                  mmio_read,
  output logic                  mmio_write,
  output logic [ADDR_WIDTH-1:0] mmio_addr,
  output logic [DATA_WIDTH-1:0] mmio_wr_data,
  input  logic [DATA_WIDTH-1:0] mmio_rd_data
);

  arb_state_t state_q, state_d;

  logic                  win_q, win_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  last_grant_q, last_grant_d;
  logic                  cs_q, cs_d;
  logic                  rstb_q, rstb_d;
  logic                  wstb_q, wstb_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic                  err_out_q, err_out_d;

  logic                  pick_idx;
  logic                  any_req;
  logic                  sel_rd;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  fpro_rr_pick u_pick (
    .req        (req_i),
    .last_grant (last_grant_q),
    .grant_idx  (pick_idx),
    .any_req    (any_req)
  );

  // Command fields of whichever requester the selector currently favours.
  always_comb begin
    sel_rd    = rd_i[pick_idx];
    sel_wr    = wr_i[pick_idx];
    sel_addr  = pick_idx ? addr1_i : addr0_i;
    sel_wdata = pick_idx ? wr_data1_i : wr_data0_i;
  end

  // Next-state and next-output logic. Strobes, ack and err are computed one
  // cycle ahead and registered, so the bus sees glitch-free single-cycle
  // pulses. Requester inputs are only looked at in IDLE; the command is
  // frozen in registers for the rest of the transaction.
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    last_grant_d = last_grant_q;
    cs_d         = 1'b0;
    rstb_d       = 1'b0;
    wstb_d       = 1'b0;
    ack_d        = '0;
    err_out_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          win_d   = pick_idx;
          rd_d    = sel_rd;
          wr_d    = sel_wr;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          err_d   = ~(sel_rd ^ sel_wr);
          if (sel_rd ^ sel_wr) begin
            state_d = ISSUE;
            cs_d    = 1'b1;
            rstb_d  = sel_rd;
            wstb_d  = sel_wr;
          end else begin
            // Neither or both commands: skip the bus and report an error.
            state_d   = ACK;
            ack_d     = pick_idx ? 2'b10 : 2'b01;
            err_out_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d      = ACK;
        last_grant_d = win_q;
        ack_d        = win_q ? 2'b10 : 2'b01;
        if (rd_q) begin
          rdata_d = mmio_rd_data;
        end
      end
      ACK: begin
        state_d = IDLE;
        // Illegal commands never pass through ISSUE, so record the grant here.
        if (err_q) begin
          last_grant_d = win_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers. last_grant resets to 1 so requester 0 wins
  // the first contention; reset also kills any strobe in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      win_q        <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      last_grant_q <= 1'b1;
      cs_q         <= 1'b0;
      rstb_q       <= 1'b0;
      wstb_q       <= 1'b0;
      ack_q        <= '0;
      err_out_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      last_grant_q <= last_grant_d;
      cs_q         <= cs_d;
      rstb_q       <= rstb_d;
      wstb_q       <= wstb_d;
      ack_q        <= ack_d;
      err_out_q    <= err_out_d;
    end
  end

  assign ack_o        = ack_q;
  assign err_o        = err_out_q;
  assign rd_data_o    = rdata_q;
  assign mmio_cs      = cs_q;
  assign mmio_read    = rstb_q;
  assign mmio_write   = wstb_q;
  assign mmio_addr    = addr_q;
  assign mmio_wr_data = wdata_q;

endmodule

// File: tb/tb_fpro_mmio_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpro_mmio_arbiter
// Self-checking bench for fpro_mmio_arbiter. A transaction-level timeline
// model predicts, for every cycle, the strobes, acks and held register
// values; every cycle the DUT outputs are compared against it. Directed
// scenarios add literal expectations, then a randomized phase exercises
// contention, illegal commands, input churn and random resets.
// ---------------------------------------------------------------------------
module tb_fpro_mmio_arbiter;

  localparam int AW   = 21;
  localparam int DW   = 32;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_i, rd_i, wr_i;
  logic [AW-1:0] addr0_i, addr1_i;
  logic [DW-1:0] wr_data0_i, wr_data1_i;
  logic [1:0]    ack_o;
  logic          err_o;
  logic [DW-1:0] rd_data_o;
  logic          mmio_cs, mmio_read, mmio_write;
  logic [AW-1:0] mmio_addr;
  logic [DW-1:0] mmio_wr_data;
  logic [DW-1:0] mmio_rd_data;

  fpro_mmio_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_i        (req_i),
    .rd_i         (rd_i),
    .wr_i         (wr_i),
    .addr0_i      (addr0_i),
    .addr1_i      (addr1_i),
    .wr_data0_i   (wr_data0_i),
    .wr_data1_i   (wr_data1_i),
    .ack_o        (ack_o),
    .err_o        (err_o),
    .rd_data_o    (rd_data_o),
    .mmio_cs      (mmio_cs),
    .mmio_read    (mmio_read),
    .mmio_write   (mmio_write),
    .mmio_addr    (mmio_addr),
    .mmio_wr_data (mmio_wr_data),
    .mmio_rd_data (mmio_rd_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Timeline of expected events, indexed by cycle.
  bit          exp_cs     [MAXC];
  bit          exp_rd     [MAXC];
  bit          exp_wr     [MAXC];
  bit          exp_err    [MAXC];
  bit [1:0]    exp_ack    [MAXC];
  bit          upd_valid  [MAXC];
  bit [AW-1:0] upd_addr   [MAXC];
  bit [DW-1:0] upd_wdata  [MAXC];
  bit          take_rdata [MAXC];
  bit          zero_at    [MAXC];
  bit [DW-1:0] drv_rdata  [MAXC];

  bit [AW-1:0] hold_addr  = '0;
  bit [DW-1:0] hold_wdata = '0;
  bit [DW-1:0] hold_rdata = '0;
  int          free_at    = 0;
  bit          last_win   = 1'b1;
  int          owner      = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Compare every DUT output with the model's view of the current cycle.
  task automatic checkOutput();
    if (zero_at[cyc]) begin
      hold_addr  = '0;
      hold_wdata = '0;
      hold_rdata = '0;
    end
    if (upd_valid[cyc]) begin
      hold_addr  = upd_addr[cyc];
      hold_wdata = upd_wdata[cyc];
    end
    if (take_rdata[cyc]) hold_rdata = drv_rdata[cyc-1];
    cmp("mmio_cs",      32'(mmio_cs),      32'(exp_cs[cyc]));
    cmp("mmio_read",    32'(mmio_read),    32'(exp_rd[cyc]));
    cmp("mmio_write",   32'(mmio_write),   32'(exp_wr[cyc]));
    cmp("ack_o",        32'(ack_o),        32'(exp_ack[cyc]));
    cmp("err_o",        32'(err_o),        32'(exp_err[cyc]));
    cmp("mmio_addr",    32'(mmio_addr),    32'(hold_addr));
    cmp("mmio_wr_data", mmio_wr_data,      hold_wdata);
    cmp("rd_data_o",    rd_data_o,         hold_rdata);
  endtask

  // Transaction-level model: when the bus is free and someone requests,
  // schedule the strobe/ack events of the resulting transaction.
  task automatic modelStep();
    bit w, rd, wr;
    drv_rdata[cyc] = mmio_rd_data;
    if (reset) begin
      for (int k = cyc + 1; k <= cyc + 3; k++) begin
        exp_cs[k] = 0; exp_rd[k] = 0; exp_wr[k] = 0; exp_err[k] = 0;
        exp_ack[k] = 0; upd_valid[k] = 0; take_rdata[k] = 0;
      end
      zero_at[cyc+1] = 1;
      free_at  = cyc + 1;
      last_win = 1'b1;
    end else if (cyc >= free_at && req_i != 2'b00) begin
      w  = (req_i == 2'b11) ? ~last_win : req_i[1];
      rd = rd_i[w];
      wr = wr_i[w];
      last_win = w;
      owner    = int'(w);
      upd_valid[cyc+1] = 1;
      upd_addr[cyc+1]  = w ? addr1_i : addr0_i;
      upd_wdata[cyc+1] = w ? wr_data1_i : wr_data0_i;
      if (rd != wr) begin
        exp_cs[cyc+1]     = 1;
        exp_rd[cyc+1]     = rd;
        exp_wr[cyc+1]     = wr;
        exp_ack[cyc+2]    = w ? 2'b10 : 2'b01;
        take_rdata[cyc+2] = rd;
        free_at = cyc + 3;
      end else begin
        exp_ack[cyc+1] = w ? 2'b10 : 2'b01;
        exp_err[cyc+1] = 1;
        free_at = cyc + 2;
      end
    end
  endtask

  task automatic tick();
    if (cyc + 4 >= MAXC) begin
      $display("[TB] FAIL cycle_budget cyc=%0d actual=%0d required=<%0d", cyc, cyc, MAXC - 4);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    modelStep();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    checkOutput();
  endtask

  task automatic newCmd(input int i);
    int r;
    r = int'($urandom_range(0, 7));
    rd_i[i] = (r == 0) || (r >= 2 && r < 5);
    wr_i[i] = (r == 0) || (r >= 5);
    if (i == 0) begin
      addr0_i    = AW'($urandom());
      wr_data0_i = $urandom();
    end else begin
      addr1_i    = AW'($urandom());
      wr_data1_i = $urandom();
    end
  endtask

  // Random agents: each requester holds its command until acked, then
  // either issues another or goes quiet; the in-flight owner may churn.
  task automatic applyStimulus();
    mmio_rd_data = $urandom();
    reset = ($urandom_range(0, 99) == 0);
    for (int i = 0; i < 2; i++) begin
      if (req_i[i] && exp_ack[cyc][i]) begin
        if ($urandom_range(0, 1) == 1) newCmd(i);
        else req_i[i] = 1'b0;
      end else if (!req_i[i]) begin
        if ($urandom_range(0, 2) == 0) begin
          req_i[i] = 1'b1;
          newCmd(i);
        end
      end else if (cyc < free_at && owner == i && $urandom_range(0, 3) == 0) begin
        if (i == 0) addr0_i = AW'($urandom());
        else        wr_data1_i = $urandom();
      end
    end
  endtask

  initial begin
    int strobes, acks;
    reset = 1'b1;
    req_i = '0; rd_i = '0; wr_i = '0;
    addr0_i = '0; addr1_i = '0; wr_data0_i = '0; wr_data1_i = '0;
    mmio_rd_data = '0;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    checkOutput();
    cmp("reset_rd_data", rd_data_o, 32'h0);
    cmp("reset_ack", 32'(ack_o), 32'h0);

    // Single read from requester 0.
    addr0_i = 21'h12; req_i = 2'b01; rd_i = 2'b01; wr_i = 2'b00;
    mmio_rd_data = 32'hDEADBEEF;
    tick();
    cmp("t1_cs", 32'(mmio_cs), 32'h1);
    cmp("t1_read", 32'(mmio_read), 32'h1);
    cmp("t1_addr", 32'(mmio_addr), 32'h12);
    tick();
    cmp("t1_ack", 32'(ack_o), 32'h1);
    cmp("t1_err", 32'(err_o), 32'h0);
    cmp("t1_rdata", rd_data_o, 32'hDEADBEEF);
    req_i = 2'b00; rd_i = 2'b00;
    tick();
    cmp("t1_cs_off", 32'(mmio_cs), 32'h0);

    // Contention straight after reset, both writing.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_i = 2'b11; rd_i = 2'b00; wr_i = 2'b11;
    addr0_i = 21'h10; addr1_i = 21'h20; wr_data0_i = 32'hA0; wr_data1_i = 32'hB0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k % 3 == 1) begin
        cmp("t2_wstrobe", 32'(mmio_write), 32'h1);
        cmp("t2_addr", 32'(mmio_addr), ((k / 3) % 2 == 0) ? 32'h10 : 32'h20);
      end
      if (k % 3 == 2) cmp("t2_ack", 32'(ack_o), ((k / 3) % 2 == 0) ? 32'h1 : 32'h2);
      if (k == 11) begin req_i = 2'b00; wr_i = 2'b00; end
    end

    // Requester 0 write, then an illegal command from requester 1.
    req_i = 2'b01; wr_i = 2'b01; addr0_i = 21'h40;
    tick(); tick();
    req_i = 2'b00; wr_i = 2'b00;
    tick();
    req_i = 2'b10; rd_i = 2'b10; wr_i = 2'b10; addr1_i = 21'h33;
    tick();
    cmp("t3_ack", 32'(ack_o), 32'h2);
    cmp("t3_err", 32'(err_o), 32'h1);
    cmp("t3_cs", 32'(mmio_cs), 32'h0);
    req_i = 2'b11; rd_i = 2'b10; wr_i = 2'b11; addr0_i = 21'h44;
    tick(); tick();
    cmp("t3_next_addr", 32'(mmio_addr), 32'h44);
    cmp("t3_next_write", 32'(mmio_write), 32'h1);
    req_i = 2'b00; rd_i = 2'b00; wr_i = 2'b00;
    tick(); tick();

    // Input churn on requester 1 while its write is on the bus.
    req_i = 2'b10; wr_i = 2'b10; addr1_i = 21'h55; wr_data1_i = 32'h1234;
    tick();
    addr1_i = 21'h7777; wr_data1_i = 32'hFFFF;
    tick();
    cmp("t4_addr_hold", 32'(mmio_addr), 32'h55);
    cmp("t4_data_hold", mmio_wr_data, 32'h1234);
    req_i = 2'b00; wr_i = 2'b00;
    tick();

    // Reset in the middle of requester 0's second write.
    req_i = 2'b01; wr_i = 2'b01; addr0_i = 21'h66; wr_data0_i = 32'h66;
    tick(); tick(); tick(); tick();
    cmp("t5_cs_before", 32'(mmio_cs), 32'h1);
    reset = 1'b1;
    tick();
    cmp("t5_cs", 32'(mmio_cs), 32'h0);
    cmp("t5_write", 32'(mmio_write), 32'h0);
    cmp("t5_ack", 32'(ack_o), 32'h0);
    cmp("t5_addr", 32'(mmio_addr), 32'h0);
    reset = 1'b0;
    req_i = 2'b11; wr_i = 2'b11; addr0_i = 21'h70; addr1_i = 21'h71;
    tick();
    cmp("t5_grant_addr", 32'(mmio_addr), 32'h70);
    tick();
    cmp("t5_grant_ack", 32'(ack_o), 32'h1);
    req_i = 2'b00; wr_i = 2'b00;
    tick();

    // Requester 0 streams five writes back to back.
    strobes = 0; acks = 0;
    req_i = 2'b01; wr_i = 2'b01; addr0_i = 21'h100;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (mmio_write) strobes++;
      if (ack_o[0]) acks++;
      if (k % 3 == 1 && k <= 13) cmp("t6_strobe_slot", 32'(mmio_write), 32'h1);
      if (k % 3 == 2 && k <= 14) begin
        addr0_i = AW'(32'h100 + 32'(k));
        if (k == 14) begin req_i = 2'b00; wr_i = 2'b00; end
      end
    end
    cmp("t6_strobes", 32'(strobes), 32'h5);
    cmp("t6_acks", 32'(acks), 32'h5);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      applyStimulus();
      tick();
    end
    reset = 1'b0;
    req_i = 2'b00;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpro_mmio_arbiter.md
# fpro_mmio_arbiter

Shares the single FPro MMIO bus between two masters: the CPU-side bridge (requester 0) and a secondary master such as a DMA or a test sequencer (requester 1). It sits between the bridge outputs and the MMIO wrapper inputs. It grants one requester at a time with round-robin fairness, issues exactly one single-cycle MMIO strobe per transaction and returns the registered read data with an acknowledge pulse.

## Interface
Parameters:
- ADDR_WIDTH, 21: MMIO word-address width.
- DATA_WIDTH, 32: MMIO data width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_i  in  2  per-requester request; held high with stable command until ack.
- rd_i  in  2  per-requester read command.
- wr_i  in  2  per-requester write command.
- addr0_i, addr1_i  in  ADDR_WIDTH  requester addresses.
- wr_data0_i, wr_data1_i  in  DATA_WIDTH  requester write data.
- ack_o  out  2  one-cycle completion pulse per requester.
- err_o  out  1  valid with ack_o; high means the command was illegal and no bus cycle occurred.
- rd_data_o  out  DATA_WIDTH  read data, valid only in the ack_o cycle of a read.
- mmio_cs  out  1  MMIO chip select.
- mmio_read  out  1  MMIO read strobe.
- mmio_write  out  1  MMIO write strobe.
- mmio_addr  out  ADDR_WIDTH  MMIO address.
- mmio_wr_data  out  DATA_WIDTH  MMIO write data.
- mmio_rd_data  in  DATA_WIDTH  MMIO read data, combinationally valid during the read strobe.

## Operation
- States: IDLE, ISSUE, ACK.
- IDLE:
  - If any req_i bit is high, pick a winner. A single request wins outright. If both are high, the requester not granted last wins.
  - Latch the winner's index, rd, wr, addr and wr_data into command registers.
  - Go to ISSUE if exactly one of rd/wr is set. Otherwise (both set or neither set) go to ACK with the error flag set.
- ISSUE:
  - Drive mmio_cs=1, mmio_read=rd, mmio_write=wr, mmio_addr and mmio_wr_data from the latched command.
  - On a read, capture mmio_rd_data into the read-data register.
  - Update last_grant to the winner. Go to ACK.
- ACK:
  - Pulse ack_o[winner]. Drive err_o from the error flag. rd_data_o shows the captured register.
  - Go to IDLE.
  - An illegal command also updates last_grant.
- Outside ISSUE, all mmio_* strobes and mmio_cs are 0. mmio_addr and mmio_wr_data hold the last latched values.
- Outside ACK, ack_o=0 and err_o=0. rd_data_o holds its register; it is not zeroed.
- Requester inputs are sampled only in IDLE. Changes during ISSUE or ACK are ignored.
- A requester that keeps req high after its ack starts a new transaction. If the other requester is also pending, the other requester wins.

## Timing
- Reset values: state=IDLE, last_grant=1 (so requester 0 wins the first contention), all outputs 0, all command and data registers 0.
- Latency:
  - req seen in IDLE at cycle N.
  - Strobe at cycle N+1.
  - ack at cycle N+2.
  - Earliest next IDLE sample at N+3, so one transaction per 3 cycles.
- Illegal command: ack with err_o=1 at N+1. No strobe is issued.
- Reset asserted in any state:
  - Next edge returns to IDLE and clears all registers.
  - A strobe in progress ends at that edge; no ack is issued for the aborted transaction.
- Strobes are registered, glitch-free and exactly one cycle wide.

## Structure
- Package fpro_arb_pkg holds:
  - state enum arb_state_t {IDLE, ISSUE, ACK};
  - constant NUM_REQ=2;
  - default widths ADDR_W=21 and DATA_W=32.
- Sub-module fpro_rr_pick: combinational 2-way round-robin selector. Inputs are req[1:0] and last_grant. Outputs are grant_idx and any_req.
- The top level holds the FSM and the command/data registers. Target size is 150–250 lines.

## Test plan
- Single read: req_i=01, rd_i=01, addr0=0x00012; mmio_rd_data=0xDEADBEEF during the strobe. Required: mmio_read and mmio_cs high for exactly 1 cycle at N+1; ack_o=01 at N+2; rd_data_o=0xDEADBEEF; err_o=0.
- Contention: req_i=11 immediately after reset, both writing (addr0=0x10, addr1=0x20), reqs held. Required: the first strobe uses addr 0x10 and the second uses 0x20; the two grants alternate 0,1,0,1 across 4 transactions, each 3 cycles apart.
- Illegal command: requester 1 sets rd=1 and wr=1. Required: no mmio_cs or strobe; ack_o=10 with err_o=1 at N+1. Requester 0 is granted next under contention.
- Input churn: change addr1 and wr_data1 during ISSUE. Required: mmio_addr and mmio_wr_data keep the values latched in IDLE.
- Reset mid-transaction: assert reset during ISSUE. Required: strobes low at the next edge, no ack pulse, all outputs 0, and the next contention goes to requester 0.
- Back-to-back single requester: requester 0 holds req with 5 successive write commands. Required: exactly 5 one-cycle strobes spaced 3 cycles apart and 5 acks.
